// File: rtl/draw_board_tiles.sv
// -----------------------------------------------------------------------------
// draw_board_tiles
//   Three-stage VGA overlay that paints the Minesweeper cell grid on top of the
//   background stream. Cell position is tracked with offset/index counters, so
//   no divider or multiplier sits on hcount/vcount. Each cell's code is fetched
//   from the board-state RAM through a synchronous read port.
//
//   Pipeline:
//     stage 1 : counters, cell_addr and a copy of the input stream registered
//     stage 2 : RAM returns cell_data for the registered address
//     stage 3 : colour select, all output fields registered
//
// Ports:
//   clk          pixel clock
//   rst          asynchronous, active-high reset
//   i_vcount ..  upstream timing (vcount, vsync, vblnk, hcount, hsync, hblnk)
//   i_rgb        upstream colour, 12-bit 4:4:4
//   o_vcount ..  downstream timing, same fields, 3 clocks later
//   o_rgb        downstream colour
//   i_board_en   1 = draw the board, 0 = pass rgb through
//   o_cell_addr  board RAM read address {row[3:0], col[3:0]}
//   i_cell_data  cell code, valid one clock after o_cell_addr is registered
// -----------------------------------------------------------------------------
module draw_board_tiles #(
   parameter int BOARD_X   = 256,
   parameter int BOARD_Y   = 128,
   parameter int CELL_SIZE = 32,
   parameter int COLS      = 16,
   parameter int ROWS      = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] i_vcount,
   input  logic        i_vsync,
   input  logic        i_vblnk,
   input  logic [10:0] i_hcount,
   input  logic        i_hsync,
   input  logic        i_hblnk,
   input  logic [11:0] i_rgb,
   output logic [10:0] o_vcount,
   output logic        o_vsync,
   output logic        o_vblnk,
   output logic [10:0] o_hcount,
   output logic        o_hsync,
   output logic        o_hblnk,
   output logic [11:0] o_rgb,
   input  logic        i_board_en,
   output logic [7:0]  o_cell_addr,
   input  logic [3:0]  i_cell_data
);

   localparam int OW = $clog2(CELL_SIZE);
   typedef logic [OW-1:0] off_t;

   localparam logic [10:0] X_LO = 11'(BOARD_X);
   localparam logic [10:0] X_HI = 11'(BOARD_X + COLS * CELL_SIZE);
   localparam logic [10:0] Y_LO = 11'(BOARD_Y);
   localparam logic [10:0] Y_HI = 11'(BOARD_Y + ROWS * CELL_SIZE);

   // CELL_SIZE is a power of two, so the last offset is all ones.
   localparam off_t OFF_MAX = '1;
   localparam off_t SQ8_LO  = off_t'(CELL_SIZE / 2 - 4);
   localparam off_t SQ8_HI  = off_t'(CELL_SIZE / 2 + 4);
   localparam off_t SQ12_LO = off_t'(CELL_SIZE / 2 - 6);
   localparam off_t SQ12_HI = off_t'(CELL_SIZE / 2 + 6);

   typedef struct packed {
      logic [10:0] vcount;
      logic        vsync;
      logic        vblnk;
      logic [10:0] hcount;
      logic        hsync;
      logic        hblnk;
      logic [11:0] rgb;
   } vga_t;

   // ---------------------------------------------------------------- helpers
   function automatic logic in_square(input off_t xo, input off_t yo,
                                      input off_t lo, input off_t hi);
      in_square = (xo >= lo) && (xo < hi) && (yo >= lo) && (yo < hi);
   endfunction

   function automatic logic [11:0] digit_colour(input logic [3:0] code);
      case (code)
         4'd1:    digit_colour = 12'h00F;
         4'd2:    digit_colour = 12'h080;
         4'd3:    digit_colour = 12'hF00;
         4'd4:    digit_colour = 12'h008;
         4'd5:    digit_colour = 12'h800;
         4'd6:    digit_colour = 12'h088;
         4'd7:    digit_colour = 12'h000;
         default: digit_colour = 12'h888;
      endcase
   endfunction

   function automatic logic [11:0] tile_colour(input logic [3:0] code,
                                               input off_t xo, input off_t yo);
      logic        sq8;
      logic        sq12;
      logic [11:0] hidden;
      sq8    = in_square(xo, yo, SQ8_LO, SQ8_HI);
      sq12   = in_square(xo, yo, SQ12_LO, SQ12_HI);
      // Raised-tile highlight on the two pixels after the grid line.
      hidden = (xo == off_t'(1) || xo == off_t'(2) ||
                yo == off_t'(1) || yo == off_t'(2)) ? 12'hFFF : 12'hAAA;
      // Only the top/left line is drawn per cell; the right/bottom border is the
      // neighbour's line, or the background past the last column/row.
      if (xo == '0 || yo == '0) begin
         tile_colour = 12'h444;
      end else begin
         case (code)
            4'd0:                                   tile_colour = 12'hCCC;
            4'd1, 4'd2, 4'd3, 4'd4,
            4'd5, 4'd6, 4'd7, 4'd8:                 tile_colour = sq8  ? digit_colour(code) : 12'hCCC;
            4'd10:                                  tile_colour = sq8  ? 12'hF00 : hidden;
            4'd11:                                  tile_colour = sq12 ? 12'h000 : 12'hCCC;
            4'd12:                                  tile_colour = sq12 ? 12'h000 : 12'hF00;
            default:                                tile_colour = hidden;  // 9, 13..15
         endcase
      end
   endfunction

   // --------------------------------------------------------------- stage 1
   vga_t w_in;
   assign w_in = {i_vcount, i_vsync, i_vblnk, i_hcount, i_hsync, i_hblnk, i_rgb};

   logic w_in_width;    // strictly past the first board column, inside the width
   logic w_in_height;   // strictly past the first board line, inside the height
   logic w_inside;
   assign w_in_width  = (i_hcount > X_LO) && (i_hcount < X_HI);
   assign w_in_height = (i_vcount > Y_LO) && (i_vcount < Y_HI);
   assign w_inside    = (i_hcount >= X_LO) && (i_hcount < X_HI) &&
                        (i_vcount >= Y_LO) && (i_vcount < Y_HI) &&
                        !i_hblnk && !i_vblnk;

   off_t       r_x_off, r_y_off, w_x_off, w_y_off;
   logic [3:0] r_col, r_row, w_col, w_row;

   // NOTE: every combinational output gets a default first so no path leaves it
   // unassigned; a missing default here would infer a latch.
   always_comb begin
      w_x_off = r_x_off;
      w_col   = r_col;
      w_y_off = r_y_off;
      w_row   = r_row;
      if (i_hcount == X_LO) begin
         w_x_off = '0;
         w_col   = '0;
      end else if (w_in_width) begin
         if (r_x_off == OFF_MAX) begin
            w_x_off = '0;
            w_col   = r_col + 4'd1;
         end else begin
            w_x_off = r_x_off + off_t'(1);
         end
      end
      // Vertical tracking steps once per line, on the hcount==0 pixel.
      if (i_hcount == 11'd0) begin
         if (i_vcount == Y_LO) begin
            w_y_off = '0;
            w_row   = '0;
         end else if (w_in_height) begin
            if (r_y_off == OFF_MAX) begin
               w_y_off = '0;
               w_row   = r_row + 4'd1;
            end else begin
               w_y_off = r_y_off + off_t'(1);
            end
         end
      end
   end

   // ----------------------------------------------------- pipeline registers
   vga_t       r_s1, r_s2, r_out;
   logic       r_s1_inside, r_s1_en, r_s2_inside, r_s2_en;
   off_t       r_s2_x_off, r_s2_y_off;
   logic [7:0] r_cell_addr;
   logic [11:0] w_rgb;

   always_comb begin
      w_rgb = r_s2.rgb;
      if (r_s2_inside && r_s2_en) begin
         w_rgb = tile_colour(i_cell_data, r_s2_x_off, r_s2_y_off);
      end
   end

   // NOTE: non-blocking assignments so every stage samples the previous stage's
   // value from before this edge; blocking here would collapse the pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1        <= '0;
         r_s1_inside <= 1'b0;
         r_s1_en     <= 1'b0;
         r_x_off     <= '0;
         r_y_off     <= '0;
         r_col       <= '0;
         r_row       <= '0;
         r_cell_addr <= '0;
         r_s2        <= '0;
         r_s2_inside <= 1'b0;
         r_s2_en     <= 1'b0;
         r_s2_x_off  <= '0;
         r_s2_y_off  <= '0;
         r_out       <= '0;
      end else begin
         // stage 1
         r_s1        <= w_in;
         r_s1_inside <= w_inside;
         r_s1_en     <= i_board_en;
         r_x_off     <= w_x_off;
         r_y_off     <= w_y_off;
         r_col       <= w_col;
         r_row       <= w_row;
         r_cell_addr <= {w_row, w_col};
         // stage 2: the RAM is reading r_cell_addr in parallel
         r_s2        <= r_s1;
         r_s2_inside <= r_s1_inside;
         r_s2_en     <= r_s1_en;
         r_s2_x_off  <= r_x_off;
         r_s2_y_off  <= r_y_off;
         // stage 3
         r_out       <= r_s2;
         r_out.rgb   <= w_rgb;
      end
   end

   assign o_vcount    = r_out.vcount;
   assign o_vsync     = r_out.vsync;
   assign o_vblnk     = r_out.vblnk;
   assign o_hcount    = r_out.hcount;
   assign o_hsync     = r_out.hsync;
   assign o_hblnk     = r_out.hblnk;
   assign o_rgb       = r_out.rgb;
   assign o_cell_addr = r_cell_addr;

endmodule

// File: tb/tb_draw_board_tiles.sv
// -----------------------------------------------------------------------------
// tb_draw_board_tiles
//   Randomised raster stimulus against a reference model that derives each
//   pixel's cell and offset by division from the board geometry and applies the
//   tile colour rules directly. A synchronous board RAM model feeds the DUT.
// -----------------------------------------------------------------------------
module tb_draw_board_tiles;

   localparam int BX = 256;
   localparam int BY = 128;
   localparam int CS = 32;
   localparam int NC = 16;
   localparam int NR = 16;

   typedef struct packed {
      logic [10:0] vcount;
      logic        vsync;
      logic        vblnk;
      logic [10:0] hcount;
      logic        hsync;
      logic        hblnk;
      logic [11:0] rgb;
   } px_t;

   typedef struct {
      px_t         px;
      logic [11:0] rgb;
      logic        lit_en;
      logic [11:0] lit;
   } exp_t;

   typedef struct {
      int          h;
      int          v;
      bit          pass;
      bit          blank;
      logic [11:0] rgb;
      bit          addr_en;
      logic [7:0]  addr;
   } watch_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   px_t         drv = '0;
   logic        board_en = 1'b0;
   logic [10:0] o_vcount, o_hcount;
   logic        o_vsync, o_vblnk, o_hsync, o_hblnk;
   logic [11:0] o_rgb;
   logic [7:0]  cell_addr;
   logic [3:0]  cell_data;
   logic [25:0] obs_timing;

   logic [3:0]  board [256];
   exp_t        exp_q [$];
   watch_t      watch_q [$];

   int n_tests = 0;
   int n_fail  = 0;
   int en_mode = 0;        // 0: always off, 1: always on, 2: random toggling
   bit cur_en  = 1'b0;
   bit rand_blank = 1'b0;

   always #5 clk = ~clk;

   // Synchronous-read board RAM.
   always @(posedge clk) cell_data <= board[cell_addr];

   assign obs_timing = {o_vcount, o_vsync, o_vblnk, o_hcount, o_hsync, o_hblnk};

   draw_board_tiles #(
      .BOARD_X(BX), .BOARD_Y(BY), .CELL_SIZE(CS), .COLS(NC), .ROWS(NR)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_vcount   (drv.vcount),
      .i_vsync    (drv.vsync),
      .i_vblnk    (drv.vblnk),
      .i_hcount   (drv.hcount),
      .i_hsync    (drv.hsync),
      .i_hblnk    (drv.hblnk),
      .i_rgb      (drv.rgb),
      .o_vcount   (o_vcount),
      .o_vsync    (o_vsync),
      .o_vblnk    (o_vblnk),
      .o_hcount   (o_hcount),
      .o_hsync    (o_hsync),
      .o_hblnk    (o_hblnk),
      .o_rgb      (o_rgb),
      .i_board_en (board_en),
      .o_cell_addr(cell_addr),
      .i_cell_data(cell_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------- reference model
   function automatic bit in_rect(input px_t p);
      int xr, yr;
      xr = int'(p.hcount) - BX;
      yr = int'(p.vcount) - BY;
      return (xr >= 0) && (xr < NC * CS) && (yr >= 0) && (yr < NR * CS);
   endfunction

   function automatic logic [7:0] exp_addr(input px_t p);
      int col, row;
      col = (int'(p.hcount) - BX) / CS;
      row = (int'(p.vcount) - BY) / CS;
      return 8'(row * 16 + col);
   endfunction

   function automatic bit sq(input int xo, input int yo, input int s);
      int lo, hi;
      lo = CS / 2 - s / 2;
      hi = CS / 2 + s / 2;
      return (xo >= lo) && (xo < hi) && (yo >= lo) && (yo < hi);
   endfunction

   function automatic logic [11:0] exp_rgb(input px_t p, input logic en);
      logic [11:0] digits [9];
      logic [11:0] hid;
      int xr, yr, xo, yo, code;
      digits = '{12'h000, 12'h00F, 12'h080, 12'hF00, 12'h008,
                 12'h800, 12'h088, 12'h000, 12'h888};
      if (!in_rect(p) || p.hblnk || p.vblnk || !en) return p.rgb;
      xr   = int'(p.hcount) - BX;
      yr   = int'(p.vcount) - BY;
      xo   = xr % CS;
      yo   = yr % CS;
      code = int'(board[(yr / CS) * 16 + xr / CS]);
      hid  = (xo inside {1, 2} || yo inside {1, 2}) ? 12'hFFF : 12'hAAA;
      if (xo == 0 || yo == 0) return 12'h444;
      if (code == 0) return 12'hCCC;
      if (code <= 8) return sq(xo, yo, 8) ? digits[code] : 12'hCCC;
      if (code == 10) return sq(xo, yo, 8) ? 12'hF00 : hid;
      if (code == 11) return sq(xo, yo, 12) ? 12'h000 : 12'hCCC;
      if (code == 12) return sq(xo, yo, 12) ? 12'h000 : 12'hF00;
      return hid;
   endfunction

   // --------------------------------------------------------------- stimulus
   function automatic logic next_en();
      if (en_mode == 0) cur_en = 1'b0;
      else if (en_mode == 1) cur_en = 1'b1;
      else if ($urandom_range(0, 63) == 0) cur_en = ~cur_en;
      return cur_en;
   endfunction

   function automatic px_t mk_px(input int h, input int v);
      px_t p;
      p.hcount = 11'(h);
      p.vcount = 11'(v);
      p.hsync  = 1'($urandom);
      p.vsync  = 1'($urandom);
      p.hblnk  = rand_blank && ($urandom_range(0, 15) == 0);
      p.vblnk  = rand_blank && ($urandom_range(0, 31) == 0);
      p.rgb    = 12'($urandom);
      return p;
   endfunction

   function automatic int find_watch(input int h, input int v);
      foreach (watch_q[i]) if (watch_q[i].h == h && watch_q[i].v == v) return i;
      return -1;
   endfunction

   function automatic bit is_watch_line(input int v);
      foreach (watch_q[i]) if (watch_q[i].v == v) return 1'b1;
      return 1'b0;
   endfunction

   // Drive one pixel, advance one clock, then check the address for this pixel
   // and the output for the pixel driven three clocks earlier.
   task automatic cycle(input px_t p, input logic en, input logic lit_en,
                        input logic [11:0] lit, input logic addr_en, input logic [7:0] addr_lit);
      exp_t e;
      drv      = p;
      board_en = en;
      e.px     = p;
      e.rgb    = exp_rgb(p, en);
      e.lit_en = lit_en;
      e.lit    = lit;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      if (in_rect(p)) check("cell_addr", 32'(cell_addr), 32'(exp_addr(p)));
      if (addr_en) check("cell_addr_literal", 32'(cell_addr), 32'(addr_lit));
      if (exp_q.size() == 3) begin
         e = exp_q.pop_front();
         check("timing", 32'(obs_timing), 32'(e.px[37:12]));
         check("rgb", 32'(o_rgb), 32'(e.rgb));
         if (e.lit_en) check("rgb_literal", 32'(o_rgb), 32'(e.lit));
      end
   endtask

   task automatic do_line(input int v, input bit scan, input int stop_h);
      px_t p;
      int  w;
      p = mk_px(0, v);
      cycle(p, next_en(), 1'b0, 12'h000, 1'b0, 8'h00);
      if (scan) begin
         for (int h = BX - 2; h <= stop_h; h++) begin
            p = mk_px(h, v);
            w = find_watch(h, v);
            if (w >= 0) begin
               if (watch_q[w].blank) p.hblnk = 1'b1;
               cycle(p, next_en(), 1'b1, watch_q[w].pass ? p.rgb : watch_q[w].rgb,
                     1'(watch_q[w].addr_en), watch_q[w].addr);
            end else begin
               cycle(p, next_en(), 1'b0, 12'h000, 1'b0, 8'h00);
            end
         end
      end
   endtask

   task automatic flush();
      for (int i = 0; i < 3; i++) cycle(mk_px(1, 0), 1'b0, 1'b0, 12'h000, 1'b0, 8'h00);
   endtask

   task automatic do_frame(input int scan_div, input int last_v);
      bit scan;
      for (int v = BY - 2; v <= last_v; v++) begin
         scan = ($urandom_range(0, scan_div - 1) == 0) || is_watch_line(v);
         do_line(v, scan, BX + NC * CS + 1);
      end
      flush();
   endtask

   task automatic random_board();
      for (int i = 0; i < 256; i++) board[i] = 4'($urandom_range(0, 15));
   endtask

   task automatic add_watch(input int h, input int v, input bit pass, input bit blank,
                            input logic [11:0] rgb, input bit addr_en, input logic [7:0] addr);
      watch_t w;
      w.h = h; w.v = v; w.pass = pass; w.blank = blank;
      w.rgb = rgb; w.addr_en = addr_en; w.addr = addr;
      watch_q.push_back(w);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_timing"}, 32'(obs_timing), 32'h0);
      check({tag, "_rgb"}, 32'(o_rgb), 32'h0);
      check({tag, "_addr"}, 32'(cell_addr), 32'h0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      random_board();
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // Latency: board disabled, everything passes through 3 clocks later.
      en_mode = 0; rand_blank = 1'b1;
      do_frame(32, BY + NR * CS + 1);

      // Directed frame: addressing, grid, outside/blanking, flag and exploded.
      for (int i = 0; i < 256; i++) board[i] = 4'((i % 16) % 13);
      board[8'h00] = 4'd9;
      board[8'h01] = 4'd12;
      board[8'h02] = 4'd10;
      add_watch(BX + 3*CS + 16, BY + 5*CS + 16, 0, 0, 12'hF00, 1, 8'h53);
      add_watch(BX,      BY + 10, 0, 0, 12'h444, 0, 8'h00);
      add_watch(BX + 1,  BY + 10, 0, 0, 12'hFFF, 0, 8'h00);
      add_watch(BX + 10, BY + 10, 0, 0, 12'hAAA, 0, 8'h00);
      add_watch(BX - 1,  BY,      1, 0, 12'h000, 0, 8'h00);
      add_watch(BX + 40, BY + 16, 1, 1, 12'h000, 0, 8'h00);
      add_watch(BX + CS + 16,   BY + 16, 0, 0, 12'h000, 0, 8'h00);
      add_watch(BX + CS + 4,    BY + 4,  0, 0, 12'hF00, 0, 8'h00);
      add_watch(BX + 2*CS + 16, BY + 16, 0, 0, 12'hF00, 0, 8'h00);
      add_watch(BX + 2*CS + 10, BY + 10, 0, 0, 12'hAAA, 0, 8'h00);
      en_mode = 1; rand_blank = 1'b0;
      do_frame(1_000_000, BY + NR * CS + 1);
      watch_q.delete();

      // Random board, board_en toggling mid-frame, random blanking.
      random_board();
      en_mode = 2; rand_blank = 1'b1;
      do_frame(32, BY + NR * CS + 1);

      // Asynchronous reset in the middle of a drawn line.
      random_board();
      en_mode = 1; rand_blank = 1'b0;
      for (int v = BY - 2; v < BY + 40; v++) do_line(v, $urandom_range(0, 15) == 0, BX + NC * CS + 1);
      do_line(BY + 40, 1'b1, BX + 100);
      #2 rst = 1'b1;
      #1 check_all_zero("rst_async");
      @(negedge clk);
      check_all_zero("rst_held");
      rst = 1'b0;
      exp_q.delete();

      // The next full frame must match the model again.
      en_mode = 2; rand_blank = 1'b1;
      do_frame(32, BY + NR * CS + 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
